// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver: synchronizes the refresh index, inserts dead time,
// and commits new display data only at the frame wrap. Optional leading-zero blanking: SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int DEAD_CYCLES    = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  digit_sel,
  input  logic [31:0] value,
  input  logic [7:0]  dp_in,
  input  logic        load,
  output logic        load_ack,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  typedef enum logic {SHOW, DEAD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  sel_meta_p0, sel_sync_p1, sel_prev_p2;
  logic [31:0] shadow_val, disp_val;
  logic [7:0]  shadow_dp, disp_dp;
  logic        pending;
  logic        change, commit, blank;
  logic [7:0]  an_on;
  logic [6:0]  seg_on;
  logic        dp_on;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'h00;
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  4'hF: hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] pol_an(input logic [7:0] x);
    return (SEG_ACTIVE_LOW != 0) ? ~x : x;
  endfunction

  function automatic logic [6:0] pol_seg(input logic [6:0] x);
    return (SEG_ACTIVE_LOW != 0) ? ~x : x;
  endfunction

  function automatic logic pol_dp(input logic x);
    return (SEG_ACTIVE_LOW != 0) ? ~x : x;
  endfunction

`ifdef SEG7_LZB_EN
  // A digit is a leading zero while it and every higher digit are zero with no dp set.
  function automatic logic lz_blank(input logic [31:0] v, input logic [7:0] dp, input logic [2:0] k);
    logic b;
    b = (k != 3'd0);
    for (int j = 0; j < 8; j++) begin
      if ((j >= int'(k)) && ((v[4*j +: 4] != 4'h0) || dp[j])) b = 1'b0;
    end
    return b;
  endfunction

  assign blank = blank_lz && lz_blank(disp_val, disp_dp, sel_prev_p2);
`else
  logic lz_unused;
  assign lz_unused = blank_lz;
  assign blank     = 1'b0;
`endif

  assign change = (sel_sync_p1 != sel_prev_p2);
  assign commit = change && pending && (sel_sync_p1 == 3'd0) && (sel_prev_p2 == 3'd7);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (change) begin
      state_d = DEAD;
      cnt_d   = 8'(DEAD_CYCLES);
    end else if (state_q == DEAD) begin
      if (cnt_q <= 8'd1) state_d = SHOW;
      else               cnt_d   = cnt_q - 8'd1;
    end
  end

  // Outputs are registered from the next state so anodes drop on the same edge DEAD is entered.
  always_comb begin
    an_on  = 8'h00;
    seg_on = 7'h00;
    dp_on  = 1'b0;
    if (state_d == SHOW) begin
      an_on[sel_prev_p2] = 1'b1;
      if (!blank) begin
        seg_on = hex7(disp_val[{sel_prev_p2, 2'b00} +: 4]);
        dp_on  = disp_dp[sel_prev_p2];
      end
    end
  end

  // Stage p0/p1: two-flop synchronizer; stage p2: previous synchronized index.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_meta_p0 <= 3'd0;
      sel_sync_p1 <= 3'd0;
      sel_prev_p2 <= 3'd0;
      shadow_val  <= 32'h0;
      shadow_dp   <= 8'h0;
      disp_val    <= 32'h0;
      disp_dp     <= 8'h0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      state_q     <= DEAD;
      cnt_q       <= 8'(DEAD_CYCLES);
      an          <= pol_an(8'h00);
      seg         <= pol_seg(7'h00);
      dp_n        <= pol_dp(1'b0);
    end else begin
      sel_meta_p0 <= digit_sel;
      sel_sync_p1 <= sel_meta_p0;
      sel_prev_p2 <= sel_sync_p1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_ack    <= commit;
      if (commit) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (load)        pending <= 1'b1;
      else if (commit) pending <= 1'b0;
      an   <= pol_an(an_on);
      seg  <= pol_seg(seg_on);
      dp_n <= pol_dp(dp_on);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: table-driven digit steps scored through an expected-value queue,
// plus hand sequences for reset behaviour and optional leading-zero blanking.
module tb_seg7_scan_driver;

  localparam int DEAD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  digit_sel;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.DEAD_CYCLES(DEAD), .SEG_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digit_sel(digit_sel), .value(value), .dp_in(dp_in),
    .load(load), .load_ack(load_ack), .blank_lz(blank_lz), .an(an), .seg(seg), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic        ld;
    logic [31:0] lv;
    logic [7:0]  ldp;
    logic        ldc;
    logic [31:0] cv;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dpn;
    logic        ack;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       ack;
  } exp_t;

  vec_t tbl[25];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] d);
    @(negedge clk);
    value = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [6:0] s, input logic d, input logic k);
    exp_t e;
    e.an = a; e.seg = s; e.dpn = d; e.ack = k;
    sb.push_back(e);
  endtask

  // Change digit_sel, measure blanking latency and dead time, then score the lit digit.
  task automatic step(input logic [2:0] d, input logic ldc, input logic [31:0] lv);
    int n, off, acks;
    exp_t e;
    digit_sel = d;
    n = 0; acks = 0;
    do begin
      @(negedge clk);
      n++;
      if (load_ack) acks++;
      if (ldc && n == 2) begin value = lv; dp_in = 8'h00; load = 1'b1; end
      else load = 1'b0;
    end while (an !== 8'hFF && n < 6);
    chk("off_latency_le3", 32'(n <= 3), 32'd1);
    off = 0;
    while (an === 8'hFF && off < 300) begin
      load = 1'b0;
      off++;
      @(negedge clk);
      if (load_ack) acks++;
    end
    chk("dead_cycles", off, DEAD);
    e = sb.pop_front();
    chk("an", an, e.an);
    chk("seg", seg, e.seg);
    chk("dp_n", dp_n, e.dpn);
    chk("load_ack_count", acks, 32'(e.ack));
  endtask

  initial begin
    int w;
    tbl[0]  = '{3'd1, 1'b1, 32'h12345678, 8'h04, 1'b0, 32'h0, 8'hFD, 7'h40, 1'b1, 1'b0};
    tbl[1]  = '{3'd2, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hFB, 7'h40, 1'b1, 1'b0};
    tbl[2]  = '{3'd3, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hF7, 7'h40, 1'b1, 1'b0};
    tbl[3]  = '{3'd4, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hEF, 7'h40, 1'b1, 1'b0};
    tbl[4]  = '{3'd5, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hDF, 7'h40, 1'b1, 1'b0};
    tbl[5]  = '{3'd6, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hBF, 7'h40, 1'b1, 1'b0};
    tbl[6]  = '{3'd7, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'h7F, 7'h40, 1'b1, 1'b0};
    tbl[7]  = '{3'd0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hFE, 7'h00, 1'b1, 1'b1};
    tbl[8]  = '{3'd1, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hFD, 7'h78, 1'b1, 1'b0};
    tbl[9]  = '{3'd2, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hFB, 7'h02, 1'b0, 1'b0};
    tbl[10] = '{3'd3, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hF7, 7'h12, 1'b1, 1'b0};
    tbl[11] = '{3'd4, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hEF, 7'h19, 1'b1, 1'b0};
    tbl[12] = '{3'd5, 1'b1, 32'h000000AB, 8'h00, 1'b0, 32'h0, 8'hDF, 7'h30, 1'b1, 1'b0};
    tbl[13] = '{3'd6, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hBF, 7'h24, 1'b1, 1'b0};
    tbl[14] = '{3'd7, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'h7F, 7'h79, 1'b1, 1'b0};
    tbl[15] = '{3'd0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hFE, 7'h03, 1'b1, 1'b1};
    tbl[16] = '{3'd1, 1'b1, 32'h11111111, 8'h00, 1'b0, 32'h0, 8'hFD, 7'h08, 1'b1, 1'b0};
    tbl[17] = '{3'd2, 1'b1, 32'h22222222, 8'h00, 1'b0, 32'h0, 8'hFB, 7'h40, 1'b1, 1'b0};
    tbl[18] = '{3'd5, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hDF, 7'h40, 1'b1, 1'b0};
    tbl[19] = '{3'd7, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'h7F, 7'h40, 1'b1, 1'b0};
    tbl[20] = '{3'd0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hFE, 7'h24, 1'b1, 1'b1};
    tbl[21] = '{3'd7, 1'b1, 32'h33333333, 8'h00, 1'b0, 32'h0, 8'h7F, 7'h24, 1'b1, 1'b0};
    tbl[22] = '{3'd0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h44444444, 8'hFE, 7'h30, 1'b1, 1'b1};
    tbl[23] = '{3'd7, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'h7F, 7'h30, 1'b1, 1'b0};
    tbl[24] = '{3'd0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0, 8'hFE, 7'h19, 1'b1, 1'b1};

    reset = 1'b1; digit_sel = 3'd0; value = 32'h0; dp_in = 8'h0; load = 1'b0; blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_an", an, 8'hFF);
      chk("reset_seg", seg, 7'h7F);
      chk("reset_dp_n", dp_n, 1'b1);
      chk("reset_load_ack", load_ack, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_an_off", an, 8'hFF);
    w = 0;
    while (an === 8'hFF && w < 50) begin @(negedge clk); w++; end
    chk("first_show_an", an, 8'hFE);
    chk("first_show_seg", seg, 7'h40);

    for (int i = 0; i < 25; i++) begin
      if (tbl[i].ld) do_load(tbl[i].lv, tbl[i].ldp);
      push(tbl[i].an, tbl[i].seg, tbl[i].dpn, tbl[i].ack);
      step(tbl[i].sel, tbl[i].ldc, tbl[i].cv);
    end

    // Leading-zero blanking with value 0x50, then value 0.
    blank_lz = 1'b1;
    do_load(32'h00000050, 8'h00);
    push(8'h7F, 7'h19, 1'b1, 1'b0); step(3'd7, 1'b0, 32'h0);
    push(8'hFE, 7'h40, 1'b1, 1'b1); step(3'd0, 1'b0, 32'h0);
    for (int k = 1; k < 8; k++) begin
      logic [7:0] a;
      a = ~(8'h01 << k);
`ifdef SEG7_LZB_EN
      push(a, (k == 1) ? 7'h12 : 7'h7F, 1'b1, 1'b0);
`else
      push(a, (k == 1) ? 7'h12 : 7'h40, 1'b1, 1'b0);
`endif
      step(3'(k), 1'b0, 32'h0);
    end
    do_load(32'h0, 8'h00);
    push(8'hFE, 7'h40, 1'b1, 1'b1); step(3'd0, 1'b0, 32'h0);
`ifdef SEG7_LZB_EN
    push(8'hFD, 7'h7F, 1'b1, 1'b0);
`else
    push(8'hFD, 7'h40, 1'b1, 1'b0);
`endif
    step(3'd1, 1'b0, 32'h0);
    blank_lz = 1'b0;

    // Reset during the dead time of a pending frame wrap must drop the load silently.
    do_load(32'h55555555, 8'hFF);
    push(8'h7F, 7'h40, 1'b1, 1'b0); step(3'd7, 1'b0, 32'h0);
    digit_sel = 3'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_an", an, 8'hFF);
      chk("midreset_seg", seg, 7'h7F);
      chk("midreset_dp_n", dp_n, 1'b1);
      chk("midreset_load_ack", load_ack, 1'b0);
    end
    reset = 1'b0;
    w = 0;
    begin
      int acks;
      acks = 0;
      while (an === 8'hFF && w < 50) begin
        @(negedge clk); w++;
        if (load_ack) acks++;
      end
      chk("after_reset_ack", acks, 0);
    end
    chk("after_reset_an", an, 8'hFE);
    chk("after_reset_seg", seg, 7'h40);
    chk("after_reset_dp_n", dp_n, 1'b1);
    push(8'h7F, 7'h40, 1'b1, 1'b0); step(3'd7, 1'b0, 32'h0);
    push(8'hFE, 7'h40, 1'b1, 1'b0); step(3'd0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
